score_sequencer: RTL and testbench
==================================

SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 Parameter SLOTS, default 5: number of ring history registers (addresses 0..SLOTS-1); legal range 1..5.
REQ-002 Parameter BEST_ADDR, default 5: register address holding the best (minimum) time; SHALL be greater than SLOTS-1.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 CLRN  input  1  asynchronous, active-low reset.
REQ-005 TIME_IN  input  13  reaction-time sample.
REQ-006 TIME_VALID  input  1  sample offered; accepted on the rising edge where TIME_VALID and READY are both 1.
REQ-007 READY  output  1  sequencer can accept a sample.
REQ-008 CLEAR  input  1  empties the history (pointers and flags only).
REQ-009 COUNT  output  3  valid history entries, 0..SLOTS.
REQ-010 NEW_BEST  output  1  one-cycle pulse when a new best is written.
REQ-011 WA  output  3  register-file write address.
REQ-012 LD_DATA  output  13  register-file write data.
REQ-013 WR  output  1  register-file write enable.
REQ-014 RP  output  3  register-file read address, port P.
REQ-015 DATAP  input  13  register-file read data, port P (combinational from RP).

Function
REQ-016 States: IDLE, WR_SLOT, CMP, WR_BEST; WR, WA, LD_DATA and NEW_BEST are Moore outputs decoded from the state register.
REQ-017 READY = (state==IDLE) && !CLEAR.
REQ-018 IDLE: on acceptance, latch TIME_IN into sample register S and go to WR_SLOT; otherwise stay.
REQ-019 WR_SLOT: WR=1, WA=wptr, LD_DATA=S for exactly one cycle; wptr advances, wrapping SLOTS-1 -> 0; COUNT increments, saturating at SLOTS; next state CMP.
REQ-020 RP SHALL be held constant at BEST_ADDR in every state.
REQ-021 CMP: WR=0; if best_valid==0 or S < DATAP (unsigned, strict), go to WR_BEST; otherwise go to IDLE.
REQ-022 WR_BEST: WR=1, WA=BEST_ADDR, LD_DATA=S, NEW_BEST=1 for one cycle; best_valid is set; next state IDLE.
REQ-023 S equal to the stored best SHALL NOT count as a new best.
REQ-024 Accept-to-READY latency: 3 cycles without a new best, 4 cycles with a new best; back-to-back samples one accept every 3 or 4 cycles.
REQ-025 Outside WR_SLOT and WR_BEST: WR=0, WA=0, LD_DATA=0.
REQ-026 CLEAR in IDLE: wptr, COUNT and best_valid go to 0 on the next edge; register contents are not erased.
REQ-027 CLEAR together with TIME_VALID: CLEAR wins and the sample is not accepted.
REQ-028 CLEAR outside IDLE SHALL be ignored.

Reset
REQ-029 CLRN low: state=IDLE, S=0, wptr=0, COUNT=0, best_valid=0, WR=0, NEW_BEST=0, immediately and regardless of CLK.
REQ-030 CLRN asserted mid-sequence aborts the sequence with no further write; READY=1 on the first edge after release.

Configuration
REQ-031 Macro SCORE_BEST_TRACK_EN defined: CMP and WR_BEST exist as specified; after WR_SLOT the next state is CMP.
REQ-032 Macro SCORE_BEST_TRACK_EN undefined: no CMP or WR_BEST states; after WR_SLOT the next state is IDLE (2-cycle latency); NEW_BEST is tied to 0; RP is still tied to BEST_ADDR.

Verification
REQ-033 Reset, then samples 300, 200, 250 -> writes reg0=300 then reg5=300 (NEW_BEST); reg1=200 then reg5=200 (NEW_BEST); reg2=250 with no reg5 write; COUNT=3.
REQ-034 Six samples 10..60 with SLOTS=5 -> sixth sample written to reg0 (wrap); COUNT holds at 5; reg5=10.
REQ-035 Sample 200 after best=200 -> no WR_BEST and no NEW_BEST; READY returns after 3 cycles.
REQ-036 CLEAR and TIME_VALID together in IDLE -> no write; COUNT=0; next sample 900 written to reg0 and becomes best despite reg5 holding a smaller value.
REQ-037 CLRN pulsed low during CMP -> WR stays 0; state is IDLE; COUNT=0.
REQ-038 Macro SCORE_BEST_TRACK_EN undefined, samples 5 and 3 -> only reg0 and reg1 are written; NEW_BEST is never 1; latency is 2 cycles each.

Source files
------------

// File: rtl/score_sequencer.sv
// score_sequencer: records reaction-time samples into a ring of SLOTS
// register-file entries and, optionally, tracks the best (minimum) time at
// register address BEST_ADDR.
// Optional feature macro: SCORE_BEST_TRACK_EN (defined = best-time tracking
// with CMP/WR_BEST states; undefined = ring writes only, 2-cycle latency).
module score_sequencer #(
    parameter int SLOTS     = 5,
    parameter int BEST_ADDR = 5
) (
    input  logic        CLK,
    input  logic        CLRN,
    input  logic [12:0] TIME_IN,
    input  logic        TIME_VALID,
    output logic        READY,
    input  logic        CLEAR,
    output logic [2:0]  COUNT,
    output logic        NEW_BEST,
    output logic [2:0]  WA,
    output logic [12:0] LD_DATA,
    output logic        WR,
    output logic [2:0]  RP,
    input  logic [12:0] DATAP
);

`ifdef SCORE_BEST_TRACK_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_SLOT = 2'd1,
        CMP     = 2'd2,
        WR_BEST = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_SLOT = 2'd1
    } state_t;
`endif

    localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);
    localparam logic [2:0] FULL      = 3'(SLOTS);
    localparam logic [2:0] BEST_A    = 3'(BEST_ADDR);

    state_t      state;
    state_t      state_next;
    logic [12:0] s;
    logic [2:0]  wptr;
    logic [2:0]  count;

    // The best entry is always read; DATAP therefore always shows the stored best.
    assign RP    = BEST_A;
    assign COUNT = count;
    assign READY = (state == IDLE) && !CLEAR;

    // State register.
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sample latch, ring pointer and occupancy count.
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            s     <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLEAR) begin
                        wptr  <= '0;
                        count <= '0;
                    end else if (TIME_VALID) begin
                        s <= TIME_IN;
                    end
                end
                WR_SLOT: begin
                    wptr <= (wptr == LAST_SLOT) ? 3'd0 : wptr + 3'd1;
                    if (count != FULL) begin
                        count <= count + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCORE_BEST_TRACK_EN
    logic best_valid;

    // Best-valid flag: set once a best is written, dropped by CLEAR in IDLE.
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            best_valid <= 1'b0;
        end else if (state == IDLE && CLEAR) begin
            best_valid <= 1'b0;
        end else if (state == WR_BEST) begin
            best_valid <= 1'b1;
        end
    end

    // Next-state logic with best-time comparison.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (TIME_VALID && !CLEAR) state_next = WR_SLOT;
            WR_SLOT: state_next = CMP;
            CMP:     state_next = (!best_valid || (s < DATAP)) ? WR_BEST : IDLE;
            WR_BEST: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`else
    logic datap_unused;
    assign datap_unused = ^DATAP;

    // Next-state logic, ring writes only.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (TIME_VALID && !CLEAR) state_next = WR_SLOT;
            WR_SLOT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`endif

    // Moore write-port decode from the state register.
    always_comb begin
        WR       = 1'b0;
        WA       = '0;
        LD_DATA  = '0;
        NEW_BEST = 1'b0;
        case (state)
            WR_SLOT: begin
                WR      = 1'b1;
                WA      = wptr;
                LD_DATA = s;
            end
`ifdef SCORE_BEST_TRACK_EN
            WR_BEST: begin
                WR       = 1'b1;
                WA       = BEST_A;
                LD_DATA  = s;
                NEW_BEST = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer: directed and random samples checked against a
// behavioural model of the ring history and best-time register.
module tb_score_sequencer;
    localparam int SLOTS     = 5;
    localparam int BEST_ADDR = 5;
`ifdef SCORE_BEST_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic        CLK;
    logic        CLRN;
    logic [12:0] TIME_IN;
    logic        TIME_VALID;
    logic        READY;
    logic        CLEAR;
    logic [2:0]  COUNT;
    logic        NEW_BEST;
    logic [2:0]  WA;
    logic [12:0] LD_DATA;
    logic        WR;
    logic [2:0]  RP;
    logic [12:0] DATAP;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_wptr;
    int          m_count;
    bit          m_bv;
    int unsigned m_best;
    int unsigned mrf [8];
    bit          mvalid [8];

    // Register file attached to the sequencer
    logic [12:0] rf [8];

    score_sequencer #(.SLOTS(SLOTS), .BEST_ADDR(BEST_ADDR)) dut (
        .CLK(CLK), .CLRN(CLRN), .TIME_IN(TIME_IN), .TIME_VALID(TIME_VALID),
        .READY(READY), .CLEAR(CLEAR), .COUNT(COUNT), .NEW_BEST(NEW_BEST),
        .WA(WA), .LD_DATA(LD_DATA), .WR(WR), .RP(RP), .DATAP(DATAP)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (WR === 1'b1) rf[WA] <= LD_DATA;
    end
    assign DATAP = rf[RP];

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rf();
        for (int i = 0; i < 8; i++) begin
            if (mvalid[i]) check($sformatf("rf[%0d]", i), 32'(rf[i]), mrf[i]);
        end
    endtask

    task automatic send(input int unsigned v);
        int unsigned ea[$];
        int unsigned ed[$];
        int unsigned ca[$];
        int unsigned cd[$];
        int exp_lat;
        int exp_nb;
        int lat;
        int nb;
        int n;
        // expected behaviour from the rules
        ea.push_back(m_wptr);
        ed.push_back(v);
        m_wptr = (m_wptr + 1) % SLOTS;
        if (m_count < SLOTS) m_count++;
        exp_nb  = 0;
        exp_lat = 2;
        if (TRACK) begin
            exp_lat = 3;
            if (!m_bv || v < m_best) begin
                ea.push_back(BEST_ADDR);
                ed.push_back(v);
                m_best  = v;
                m_bv    = 1'b1;
                exp_nb  = 1;
                exp_lat = 4;
            end
        end
        foreach (ea[i]) begin
            mrf[ea[i]]    = ed[i];
            mvalid[ea[i]] = 1'b1;
        end
        // drive and observe
        @(negedge CLK);
        check("ready_before", 32'(READY), 1);
        TIME_IN    = v[12:0];
        TIME_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        TIME_VALID = 1'b0;
        lat = 1;
        nb  = 0;
        while (READY !== 1'b1 && lat < 10) begin
            if (WR === 1'b1) begin
                ca.push_back(32'(WA));
                cd.push_back(32'(LD_DATA));
            end
            if (NEW_BEST === 1'b1) nb++;
            @(negedge CLK);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("nwrites", ca.size(), ea.size());
        n = (ca.size() < ea.size()) ? ca.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            check("wr_addr", ca[i], ea[i]);
            check("wr_data", cd[i], ed[i]);
        end
        check("new_best", nb, exp_nb);
        check("count", 32'(COUNT), m_count);
        check_rf();
    endtask

    task automatic clear_with_valid(input int unsigned v);
        @(negedge CLK);
        CLEAR      = 1'b1;
        TIME_VALID = 1'b1;
        TIME_IN    = v[12:0];
        #1;
        check("ready_clear", 32'(READY), 0);
        @(posedge CLK);
        @(negedge CLK);
        CLEAR      = 1'b0;
        TIME_VALID = 1'b0;
        m_wptr  = 0;
        m_count = 0;
        m_bv    = 1'b0;
        #1;
        check("clear_wr", 32'(WR), 0);
        check("clear_count", 32'(COUNT), 0);
        check("clear_ready", 32'(READY), 1);
    endtask

    task automatic reset_mid(input int unsigned v);
        mrf[m_wptr]    = v;
        mvalid[m_wptr] = 1'b1;
        @(negedge CLK);
        check("mid_ready", 32'(READY), 1);
        TIME_IN    = v[12:0];
        TIME_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        TIME_VALID = 1'b0;
        check("mid_wr_slot", 32'(WR), 1);
        @(negedge CLK);
        CLRN = 1'b0;
        #1;
        check("rst_wr", 32'(WR), 0);
        check("rst_nb", 32'(NEW_BEST), 0);
        check("rst_ready", 32'(READY), 1);
        check("rst_count", 32'(COUNT), 0);
        @(posedge CLK);
        #1;
        check("rst_wr_hold", 32'(WR), 0);
        @(negedge CLK);
        CLRN    = 1'b1;
        m_wptr  = 0;
        m_count = 0;
        m_bv    = 1'b0;
        @(posedge CLK);
        #1;
        check("post_rst_ready", 32'(READY), 1);
        check("post_rst_wr", 32'(WR), 0);
        check_rf();
    endtask

    initial begin
        int unsigned r;
        CLRN       = 1'b0;
        CLEAR      = 1'b0;
        TIME_VALID = 1'b0;
        TIME_IN    = '0;
        m_wptr     = 0;
        m_count    = 0;
        m_bv       = 1'b0;
        m_best     = 0;
        for (int i = 0; i < 8; i++) begin
            mrf[i]    = 0;
            mvalid[i] = 1'b0;
        end
        #1;
        check("reset_ready", 32'(READY), 1);
        check("reset_count", 32'(COUNT), 0);
        check("reset_wr", 32'(WR), 0);
        check("reset_nb", 32'(NEW_BEST), 0);
        check("reset_wa", 32'(WA), 0);
        check("reset_ld", 32'(LD_DATA), 0);
        check("reset_rp", 32'(RP), BEST_ADDR);
        #12;
        @(negedge CLK);
        CLRN = 1'b1;

        send(300);
        send(200);
        send(250);
        send(200);
        for (int k = 1; k <= 6; k++) send(10 * k);
        check("rp_const", 32'(RP), BEST_ADDR);

        clear_with_valid(5);
        send(900);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) clear_with_valid($urandom_range(0, 8191));
            else if (r == 1) send(8191);
            else send($urandom_range(0, 20));
        end

        reset_mid(4000);
        send(77);
        send(77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
